// File: rtl/beat_sequencer_pkg.sv
// Shared definitions for the beat sequencer: state encoding, the idle beat marker
// and the default tempo.
package beat_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Every downstream tone lookup maps this index to silence.
  localparam logic [7:0] IDLE_BEAT   = 8'hFF;
  localparam int         DEF_BEAT_HZ = 8;

endpackage

// File: rtl/beat_sequencer_tick_divider.sv
// Free-running clock divider; tick marks the last clock of each DIV-clock period.
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/beat_sequencer.sv
// Tempo-driven beat counter: steps beatnum 0..LEN-1 once per beat period, with
// start/pause/stop control and optional looping.
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BEAT_HZ = DEF_BEAT_HZ,
  parameter int LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] beatnum,
  output logic       beat_tick,
  output logic       playing,
  output logic       done
);

  localparam int DIV = CLK_HZ / BEAT_HZ;
  localparam logic [7:0] LAST_BEAT = 8'(LEN - 1);

  state_t state;
  logic   boundary;
  logic   div_en;
  logic   div_clr;

  // The divider only advances on plain PLAY cycles; any control pulse either
  // restarts it (start/stop) or holds it (pause), which keeps paused time exact.
  assign div_en  = (state == ST_PLAY) && !stop && !start && !pause;
  assign div_clr = stop || start;

  tick_divider #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .en    (div_en),
    .tick  (boundary)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beatnum   <= IDLE_BEAT;
      beat_tick <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      done      <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        beatnum <= IDLE_BEAT;
        playing <= 1'b0;
      end else if (start) begin
        state     <= ST_PLAY;
        beatnum   <= 8'd0;
        beat_tick <= 1'b1;
        playing   <= 1'b1;
      end else begin
        case (state)
          ST_PLAY: begin
            if (pause) begin
              state <= ST_PAUSE;
            end else if (boundary) begin
              if (beatnum < LAST_BEAT) begin
                beatnum   <= beatnum + 8'd1;
                beat_tick <= 1'b1;
              end else if (loop_en) begin
                beatnum   <= 8'd0;
                beat_tick <= 1'b1;
              end else begin
                state   <= ST_IDLE;
                beatnum <= IDLE_BEAT;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (pause) state <= ST_PLAY;
          end
          ST_IDLE: ;
          default: begin
            state   <= ST_IDLE;
            beatnum <= IDLE_BEAT;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboarded bench for beat_sequencer: a beat-time reference model pushes the
// expected outputs for each edge; a monitor pops and compares after the edge.
module tb_beat_sequencer;

  localparam int CLK_HZ  = 40;
  localparam int BEAT_HZ = 4;
  localparam int LEN     = 4;
  localparam int DIV     = CLK_HZ / BEAT_HZ;

  typedef struct packed {
    logic [7:0] beatnum;
    logic       tick;
    logic       playing;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pause, stop, loop_en;
  logic [7:0] beatnum;
  logic       beat_tick, playing, done;

  int ntests = 0;
  int nfail  = 0;
  exp_t expq[$];

  // Reference model: mode 0 idle, 1 playing, 2 paused; rem = clocks left in beat.
  int   m_mode;
  int   m_beat;
  int   m_rem;
  exp_t m_out;

  beat_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .beatnum   (beatnum),
    .beat_tick (beat_tick),
    .playing   (playing),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0;
    m_beat = 255;
    m_rem  = 0;
    m_out  = '{beatnum: 8'hFF, tick: 1'b0, playing: 1'b0, done: 1'b0};
  endtask

  task automatic model_step();
    logic t, d;
    t = 1'b0;
    d = 1'b0;
    if (stop) begin
      m_mode = 0; m_beat = 255;
    end else if (start) begin
      m_mode = 1; m_beat = 0; m_rem = DIV; t = 1'b1;
    end else if (pause && m_mode == 1) begin
      m_mode = 2;
    end else if (pause && m_mode == 2) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        if (m_beat < LEN - 1) begin
          m_beat = m_beat + 1; m_rem = DIV; t = 1'b1;
        end else if (loop_en) begin
          m_beat = 0; m_rem = DIV; t = 1'b1;
        end else begin
          m_mode = 0; m_beat = 255; d = 1'b1;
        end
      end
    end
    m_out.beatnum = 8'(m_beat);
    m_out.tick    = t;
    m_out.playing = (m_mode != 0);
    m_out.done    = d;
  endtask

  // One clock of stimulus: drive on the falling edge, predict the rising edge.
  task automatic cycle(input logic s, input logic p, input logic t, input logic l);
    @(negedge clk);
    start = s; pause = p; stop = t; loop_en = l;
    if (rst_n) model_step();
    expq.push_back(m_out);
  endtask

  task automatic check_now(input string name, input exp_t want);
    exp_t got;
    got = '{beatnum: beatnum, tick: beat_tick, playing: playing, done: done};
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s t=%0t: got beatnum=%h tick=%b playing=%b done=%b, want beatnum=%h tick=%b playing=%b done=%b",
               name, $time, got.beatnum, got.tick, got.playing, got.done,
               want.beatnum, want.tick, want.playing, want.done);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) check_now("edge", expq.pop_front());
    end
  end

  initial begin : stim
    int k;
    logic lp;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_now("reset_state", m_out);

    // Idle with no stimulus, then pause/stop in idle and start+stop together.
    for (int i = 0; i < 50; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 0);

    // Full non-looping run.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4 * DIV + 5; i++) cycle(0, 0, 0, 0);

    // Looping run, then drop loop_en for a clean finish.
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 6 * DIV; i++) cycle(0, 0, 0, 1);
    for (int i = 0; i < 4 * DIV + 5; i++) cycle(0, 0, 0, 0);

    // Pause on beat 1 at cnt 4, hold 20 clocks, resume.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < DIV + 4; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 19; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 3 * DIV; i++) cycle(0, 0, 0, 0);

    // Stop coinciding with the last-beat boundary, and start on a boundary.
    for (int pass = 0; pass < 2; pass++) begin
      cycle(1, 0, 0, 0);
      k = 0;
      while (!(m_mode == 1 && m_rem == 1 && m_beat == LEN - 1 - pass) && k < 200) begin
        cycle(0, 0, 0, 0);
        k++;
      end
      ntests++;
      if (k >= 200) begin
        nfail++;
        $display("FAIL boundary_wait: got no boundary in %0d clocks, want one", k);
      end
      if (pass == 0) cycle(0, 0, 1, 0);
      else           cycle(1, 0, 0, 0);
      for (int i = 0; i < DIV + 3; i++) cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
    end

    // Restart during beat 2, then async reset mid-beat.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2 * DIV + 3; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < DIV + 2; i++) cycle(0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("async_reset", m_out);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expq.push_back(m_out);

    // Randomized control traffic.
    lp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic s, p, t;
      if ($urandom_range(0, 49) == 0) lp = ~lp;
      s = (m_mode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 99) == 0);
      cycle(s, p, t, lp);
    end
    cycle(0, 0, 0, 0);

    k = 0;
    while (expq.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (expq.size() > 0) begin
      ntests++;
      nfail++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
